// File: rtl/gauss_elim_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gauss_elim_ctrl
// Purpose  : Sweep sequencer for the GF(2^m) systolic Gaussian-elimination
//            array. Optional busy-cycle counter: GAUSS_CTRL_CYCLES_EN.
// Revision : 1.0 - initial release
// ============================================================================
module gauss_elim_ctrl #(
    parameter int WIDTH     = 13,
    parameter int N_R       = 8,
    parameter int N_C       = 16,
    parameter int ARRAY_LAT = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   fail,
`ifdef GAUSS_CTRL_CYCLES_EN
    output logic [31:0]            cycles,
`endif
    output logic                   rd_en,
    output logic [$clog2(N_R)-1:0] rd_row,
    output logic [$clog2(N_C)-1:0] rd_col,
    input  logic [WIDTH-1:0]       rd_data,
    output logic                   wr_en,
    output logic [$clog2(N_R)-1:0] wr_row,
    output logic [$clog2(N_C)-1:0] wr_col,
    output logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       arr_data_in,
    input  logic [WIDTH-1:0]       arr_data_out,
    output logic                   arr_start,
    output logic                   arr_finish,
    output logic                   arr_first_pass,
    output logic [N_R-1:0]         arr_fa,
    output logic [N_R-1:0]         arr_pass,
    input  logic [N_R-1:0]         arr_r
);

    localparam int c_rw = $clog2(N_R);
    localparam int c_cw = $clog2(N_C);
    localparam logic [c_rw-1:0] c_row_last = c_rw'(N_R - 1);
    localparam logic [c_cw-1:0] c_col_last = c_cw'(N_C - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SWEEP = 3'd1,
        S_DRAIN = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4,
        S_FAIL  = 3'd5
    } state_t;

    state_t          r_state;
    logic [c_rw-1:0] r_sweep;

    // Write-back tags: one stage for the buffer read, ARRAY_LAT for the cells.
    logic [ARRAY_LAT:0] r_dl_vld;
    logic [c_rw-1:0]    r_dl_row [ARRAY_LAT+1];
    logic [c_cw-1:0]    r_dl_col [ARRAY_LAT+1];
    logic               w_drain_pending;

    assign arr_data_in = rd_data;
    assign wr_data     = arr_data_out;
    assign wr_en       = r_dl_vld[ARRAY_LAT];
    assign wr_row      = r_dl_row[ARRAY_LAT];
    assign wr_col      = r_dl_col[ARRAY_LAT];

    // Anything still ahead of the tail means a write-back is outstanding.
    assign w_drain_pending = |r_dl_vld[ARRAY_LAT-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dl_vld <= '0;
            for (int k = 0; k <= ARRAY_LAT; k++) begin
                r_dl_row[k] <= '0;
                r_dl_col[k] <= '0;
            end
        end else begin
            r_dl_vld    <= {r_dl_vld[ARRAY_LAT-1:0], rd_en};
            r_dl_row[0] <= rd_row;
            r_dl_col[0] <= rd_col;
            for (int k = 1; k <= ARRAY_LAT; k++) begin
                r_dl_row[k] <= r_dl_row[k-1];
                r_dl_col[k] <= r_dl_col[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_sweep        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            fail           <= 1'b0;
            rd_en          <= 1'b0;
            rd_row         <= '0;
            rd_col         <= '0;
            arr_start      <= 1'b0;
            arr_finish     <= 1'b0;
            arr_first_pass <= 1'b0;
            arr_fa         <= '0;
            arr_pass       <= '0;
        end else begin
            done           <= 1'b0;
            fail           <= 1'b0;
            // Markers trail the issued address by one cycle to meet rd_data.
            arr_start      <= rd_en && (rd_col == '0);
            arr_finish     <= rd_en && (rd_col == c_col_last);
            arr_first_pass <= rd_en && (rd_row == '0);

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state  <= S_SWEEP;
                        r_sweep  <= '0;
                        busy     <= 1'b1;
                        rd_en    <= 1'b1;
                        rd_row   <= '0;
                        rd_col   <= '0;
                        arr_fa   <= {{(N_R-1){1'b0}}, 1'b1};
                        arr_pass <= '0;
                    end
                end
                S_SWEEP: begin
                    if (rd_col == c_col_last) begin
                        rd_col <= '0;
                        if (rd_row == c_row_last) begin
                            rd_row  <= '0;
                            rd_en   <= 1'b0;
                            r_state <= S_DRAIN;
                        end else begin
                            rd_row <= rd_row + 1'b1;
                        end
                    end else begin
                        rd_col <= rd_col + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (!w_drain_pending) begin
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (!arr_r[r_sweep]) begin
                        r_state <= S_FAIL;
                        busy    <= 1'b0;
                        fail    <= 1'b1;
                    end else if (r_sweep == c_row_last) begin
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        r_state  <= S_SWEEP;
                        r_sweep  <= r_sweep + 1'b1;
                        arr_pass <= arr_pass | arr_fa;
                        arr_fa   <= arr_fa << 1;
                        rd_en    <= 1'b1;
                    end
                end
                S_DONE, S_FAIL: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    rd_en   <= 1'b0;
                end
            endcase
        end
    end

`ifdef GAUSS_CTRL_CYCLES_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cycles <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            cycles <= '0;
        end else if (busy) begin
            cycles <= cycles + 32'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_gauss_elim_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_gauss_elim_ctrl
// Purpose  : Self-checking bench for gauss_elim_ctrl with buffer/array models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gauss_elim_ctrl;

    localparam int WIDTH = 13;
    localparam int N_R   = 4;
    localparam int N_C   = 8;
    localparam int LAT   = 5;
    localparam int RW    = $clog2(N_R);
    localparam int CW    = $clog2(N_C);
    localparam int NI    = N_R * N_C;
    localparam int P     = NI + LAT + 2;
    localparam logic [WIDTH-1:0] INC = 13'd3;

    logic clk = 1'b0;
    logic rst, start, load;
    logic busy, done, fail, rd_en, wr_en, arr_start, arr_finish, arr_first_pass;
    logic [RW-1:0]    rd_row, wr_row;
    logic [CW-1:0]    rd_col, wr_col;
    logic [WIDTH-1:0] rd_data, wr_data, arr_data_in, arr_data_out;
    logic [N_R-1:0]   arr_fa, arr_pass, arr_r;
`ifdef GAUSS_CTRL_CYCLES_EN
    logic [31:0]      cycles;
`endif

    always #5 clk = ~clk;

    gauss_elim_ctrl #(.WIDTH(WIDTH), .N_R(N_R), .N_C(N_C), .ARRAY_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start),
        .busy(busy), .done(done), .fail(fail),
`ifdef GAUSS_CTRL_CYCLES_EN
        .cycles(cycles),
`endif
        .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
        .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .arr_data_in(arr_data_in), .arr_data_out(arr_data_out),
        .arr_start(arr_start), .arr_finish(arr_finish),
        .arr_first_pass(arr_first_pass), .arr_fa(arr_fa), .arr_pass(arr_pass),
        .arr_r(arr_r)
    );

    // Matrix buffer plus a cell chain that adds INC to every word it carries.
    logic [WIDTH-1:0] mem      [N_R][N_C];
    logic [WIDTH-1:0] init_mem [N_R][N_C];
    logic [WIDTH-1:0] pipe     [LAT];

    always @(posedge clk) begin
        if (load) begin
            for (int r = 0; r < N_R; r++)
                for (int c = 0; c < N_C; c++)
                    mem[r][c] <= init_mem[r][c];
        end else if (wr_en) begin
            mem[wr_row][wr_col] <= wr_data;
        end
        if (rd_en) rd_data <= mem[rd_row][rd_col];
        pipe[0] <= arr_data_in + INC;
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign arr_data_out = pipe[LAT-1];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int first_zero(input logic [N_R-1:0] v);
        for (int s = 0; s < N_R; s++) if (!v[s]) return s;
        return N_R;
    endfunction

    function automatic int sweeps_for(input logic [N_R-1:0] v);
        int z = first_zero(v);
        return (z == N_R) ? N_R : z + 1;
    endfunction

    // Reference model: mk counts cycles since an accepted start (0 = idle).
    int mk      = 0;
    int m_nsw   = N_R;
    bit m_ok    = 1'b1;
    bit m_fresh = 1'b1;

    function automatic bit rd_valid(input int k);
        return (k >= 1) && (k <= m_nsw * P) && (((k - 1) % P) < NI);
    endfunction
    function automatic int rd_r(input int k);
        return ((k - 1) % P) / N_C;
    endfunction
    function automatic int rd_c(input int k);
        return ((k - 1) % P) % N_C;
    endfunction

    task automatic compare_loop();
        bit bz, last;
        int s, kw, km;
        forever begin
            @(negedge clk);
            bz   = (mk >= 1) && (mk <= m_nsw * P);
            last = (mk == m_nsw * P + 1);
            s    = (mk >= 1) ? (mk - 1) / P : 0;
            kw   = mk - 1 - LAT;
            km   = mk - 1;
            chk("busy", busy, bz);
            chk("done", done, last && m_ok);
            chk("fail", fail, last && !m_ok);
            chk("rd_en", rd_en, rd_valid(mk));
            if (rd_valid(mk)) begin
                chk("rd_row", rd_row, rd_r(mk));
                chk("rd_col", rd_col, rd_c(mk));
            end
            chk("wr_en", wr_en, rd_valid(kw));
            if (rd_valid(kw)) begin
                chk("wr_row", wr_row, rd_r(kw));
                chk("wr_col", wr_col, rd_c(kw));
            end
            chk("arr_start", arr_start, rd_valid(km) && rd_c(km) == 0);
            chk("arr_finish", arr_finish, rd_valid(km) && rd_c(km) == N_C - 1);
            chk("arr_first_pass", arr_first_pass, rd_valid(km) && rd_r(km) == 0);
            if (bz) begin
                chk("arr_fa", arr_fa, 1 << s);
                chk("arr_pass", arr_pass, (1 << s) - 1);
            end else if (m_fresh) begin
                chk("arr_fa_rst", arr_fa, 0);
                chk("arr_pass_rst", arr_pass, 0);
            end
            if (rst) begin
                mk = 0;
                m_fresh = 1'b1;
            end else if (mk == 0) begin
                if (start) begin
                    mk      = 1;
                    m_fresh = 1'b0;
                    m_nsw   = sweeps_for(arr_r);
                    m_ok    = (first_zero(arr_r) == N_R);
                end
            end else if (last) begin
                mk = 0;
            end else begin
                mk++;
            end
        end
    endtask

    task automatic load_mem(input bit ident);
        for (int r = 0; r < N_R; r++)
            for (int c = 0; c < N_C; c++)
                init_mem[r][c] = ident ? WIDTH'(r == c) : WIDTH'($urandom);
        @(posedge clk); #1 load = 1'b1;
        @(posedge clk); #1 load = 1'b0;
    endtask

    task automatic check_mem(input int nsw);
        logic [WIDTH-1:0] e;
        for (int r = 0; r < N_R; r++)
            for (int c = 0; c < N_C; c++) begin
                e = init_mem[r][c] + WIDTH'(nsw) * INC;
                chk("mem_word", mem[r][c], e);
            end
    endtask

    task automatic run(input logic [N_R-1:0] rv, input bit mid, input int abort_at, output int nb);
        int lim;
        bit ok;
        ok    = (first_zero(rv) == N_R);
        arr_r = rv;
        nb    = 0;
        lim   = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        while (lim < 2000) begin
            @(negedge clk);
            lim++;
            if (busy) begin
                nb++;
                if (nb == 1)  chk("sw0_addr_first", {rd_row, rd_col}, 5'b00_000);
                if (nb == 9)  chk("sw0_addr_row1", {rd_row, rd_col}, 5'b01_000);
                if (nb == 32) chk("sw0_addr_last", {rd_row, rd_col}, 5'b11_111);
                if (nb == 2 * P + 5) begin
                    chk("sw2_fa", arr_fa, 4'b0100);
                    chk("sw2_pass", arr_pass, 4'b0011);
                end
            end
            if (done || fail) break;
            @(posedge clk); #1;
            if (abort_at > 0 && nb == abort_at) begin
                rst = 1'b1;
                @(posedge clk); #1 rst = 1'b0;
                @(negedge clk);
                chk("abort_busy", busy, 0);
                chk("abort_wr_en", wr_en, 0);
                @(posedge clk); #1;
                return;
            end
            start = mid && (nb == 10);
        end
        chk("run_ended", done | fail, 1);
        chk("end_done", done, ok);
        chk("end_fail", fail, !ok);
`ifdef GAUSS_CTRL_CYCLES_EN
        chk("cycles", cycles, nb);
`endif
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int nb;
        logic [N_R-1:0] rv;
        rst   = 1'b1;
        start = 1'b0;
        load  = 1'b0;
        arr_r = '1;
        fork
            compare_loop();
        join_none
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        load_mem(1'b1);
        run(4'b1111, 1'b1, 0, nb);
        chk("busy_cycles_ident", nb, 156);
        check_mem(N_R);

        load_mem(1'b0);
        run(4'b1011, 1'b0, 0, nb);
        chk("busy_cycles_fail2", nb, 117);
        check_mem(3);

        load_mem(1'b0);
        run(4'b1111, 1'b0, NI + 2, nb);

        load_mem(1'b0);
        run(4'b1111, 1'b0, 0, nb);
        chk("busy_cycles_after_abort", nb, 156);
        check_mem(N_R);

        for (int t = 0; t < 4; t++) begin
            rv = N_R'($urandom_range(0, (1 << N_R) - 1));
            load_mem(1'b0);
            run(rv, 1'b1, 0, nb);
            check_mem(sweeps_for(rv));
        end

        repeat (4) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gauss_elim_ctrl.md
# gauss_elim_ctrl

Sequencer for the systolic Gaussian-elimination array built from GF(2^m) processor cells. It reads an N_R × N_C matrix of WIDTH-bit elements from a row/column-addressed buffer and streams it through the cell chain once per sweep. Per cycle it drives the cell control lines (pivot select, first_pass, pass, row start/finish markers) and writes the returned words back. After N_R sweeps it reports systematic form or failure on a singular pivot column. It sits between the key-generation top level and the processor cell chain.

## Interface
- WIDTH, 13: field element width; must equal the cell WIDTH.
- N_R, 8: matrix rows; also the number of cells in the chain.
- N_C, 16: matrix columns (words per row); N_C ≥ N_R.
- ARRAY_LAT, 9: cycles from a word entering the chain to the same word leaving it.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins elimination, ignored unless IDLE.
- busy  out  1  high from the cycle after an accepted start until DONE or FAIL is entered.
- done  out  1  one-cycle pulse; elimination succeeded.
- fail  out  1  one-cycle pulse; pivot column all-zero (matrix singular).
- rd_en  out  1  buffer read strobe; data arrives on rd_data one cycle later.
- rd_row  out  $clog2(N_R)  row address.
- rd_col  out  $clog2(N_C)  column address.
- rd_data  in  WIDTH  buffer read data.
- wr_en, wr_row, wr_col, wr_data  out  1/$clog2(N_R)/$clog2(N_C)/WIDTH  write-back port.
- arr_data_in  out  WIDTH  word into cell 0.
- arr_data_out  in  WIDTH  word from the last cell.
- arr_start, arr_finish  out  1  row-first-word / row-last-word markers into cell 0.
- arr_first_pass  out  1  high for the whole first row of a sweep.
- arr_fa  out  N_R  one-hot; bit s selects cell s as the pivot cell (functionA) in sweep s.
- arr_pass  out  N_R  bit k high when k < s (cell already settled).
- arr_r  in  N_R  per-cell r flags.

## Operation
- States: IDLE, SWEEP, DRAIN, CHECK, DONE, FAIL.
- Reset → IDLE. All counters are 0 and all outputs are 0, including arr_fa, arr_pass, done and fail.
- IDLE → SWEEP on start. Sweep counter s=0, row counter i=0, column counter j=0.
- SWEEP: issue rd_en every cycle with rd_row=i and rd_col=j. Increment j. On j=N_C-1, wrap j to 0 and increment i. When i=N_R-1 and j=N_C-1 have been issued, go to DRAIN.
- Array inputs are registered alongside the 1-cycle read:
  - arr_data_in = rd_data.
  - arr_start goes with j=0.
  - arr_finish goes with j=N_C-1.
  - arr_first_pass goes with i=0.
- arr_fa and arr_pass are held constant for the whole sweep and change only in CHECK.
- Write-back: a delay line of depth 1+ARRAY_LAT carries (valid,row,col). wr_en, wr_row and wr_col come from its tail; wr_data = arr_data_out.
- DRAIN: wait until the delay line is empty, then go to CHECK. The next sweep never reads a word before its write-back has completed.
- CHECK (one cycle): sample arr_r[s].
  - arr_r[s]=0 → FAIL.
  - arr_r[s]=1 and s=N_R-1 → DONE.
  - Otherwise s++, i=j=0, return to SWEEP.
- DONE/FAIL: pulse done/fail for one cycle, deassert busy, return to IDLE.
- start while busy is ignored.
- rst at any point aborts immediately: the delay line is flushed, no further wr_en is issued, and state is IDLE.

## Timing
- Read-to-array latency: 1 cycle. Array-to-write latency: ARRAY_LAT cycles.
- One sweep = N_R·N_C issue cycles + (1+ARRAY_LAT) drain cycles + 1 CHECK cycle.
- Successful run: busy high for N_R·(N_R·N_C + ARRAY_LAT + 2) cycles. done pulses in the cycle after the last CHECK.
- Counter wrap: j wraps only at N_C-1; i wraps only at the end of a sweep. No address exceeds N_R-1 or N_C-1.
- In the last SWEEP issue cycle and the first DRAIN cycle, reads and writes may be active together; both are legal.

## Configuration
- GAUSS_CTRL_CYCLES_EN defined:
  - Adds output cycles (32 bits). It clears on an accepted start and increments every busy cycle.
  - It holds its value after done/fail until the next start. Its reset value is 0.
- GAUSS_CTRL_CYCLES_EN undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Identity matrix, N_R=4, N_C=8 → done after exactly 4·(32+ARRAY_LAT+2) busy cycles; fail never asserted.
- Column 2 all zero (N_R=4) → fail pulses in the CHECK of sweep 2; no write issued after the FAIL entry; busy drops.
- Address sequence for sweep 0 → rd_row/rd_col = (0,0),(0,1)…(0,7),(1,0)…(3,7). arr_start on every col-0 word, arr_finish on every col-7 word, arr_first_pass only for row 0.
- Sweep 2 → arr_fa=4'b0100 and arr_pass=4'b0011, constant throughout the sweep.
- Each wr_row/wr_col equals the rd_row/rd_col issued 1+ARRAY_LAT cycles earlier. A start pulse mid-sweep is ignored.
- rst asserted mid-DRAIN → next cycle: IDLE, busy=0, wr_en=0. A new start then runs to done normally.
